// File: rtl/ex_stage_pipe_if.sv
// EX stage bus: ID/EX operands and control in, writeback forwarding, EX/MEM output side.
// dbg_state exposes the multiplier FSM state (always 0 when the multiplier is not built).
interface ex_stage_pipe_if #(
    parameter int DW  = 16,
    parameter int RW  = 4,
    parameter int SHW = $clog2(DW)
);
    // valid/ready: a transfer happens on a rising clk edge where valid && ready;
    // the producer holds its payload stable while valid is high and ready is low.
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     op;
    logic [1:0]     alu_src;
    logic [SHW-1:0] shamt;
    logic [DW-1:0]  rs_data;
    logic [DW-1:0]  rt_data;
    logic [RW-1:0]  rs_idx;
    logic [RW-1:0]  rt_idx;
    logic [RW-1:0]  dst_idx;
    logic [DW-1:0]  imm;
    logic [DW-1:0]  offset;
    logic           wb_in;
    logic [1:0]     mem_in;
    logic           wb_fwd_en;
    logic [RW-1:0]  wb_fwd_idx;
    logic [DW-1:0]  wb_fwd_data;
    logic           flush;
    logic           out_ready;
    logic           out_valid;
    logic [DW-1:0]  result;
    logic [DW-1:0]  store_data;
    logic [RW-1:0]  out_dst;
    logic           out_wb;
    logic [1:0]     out_mem;
    logic [2:0]     flags;
    logic [1:0]     dbg_state;

    modport master (
        output in_valid, op, alu_src, shamt, rs_data, rt_data, rs_idx, rt_idx, dst_idx,
               imm, offset, wb_in, mem_in, wb_fwd_en, wb_fwd_idx, wb_fwd_data, flush, out_ready,
        input  in_ready, out_valid, result, store_data, out_dst, out_wb, out_mem, flags, dbg_state
    );

    modport slave (
        input  in_valid, op, alu_src, shamt, rs_data, rt_data, rs_idx, rt_idx, dst_idx,
               imm, offset, wb_in, mem_in, wb_fwd_en, wb_fwd_idx, wb_fwd_data, flush, out_ready,
        output in_ready, out_valid, result, store_data, out_dst, out_wb, out_mem, flags, dbg_state
    );
endinterface

// File: rtl/ex_stage_pipe.sv
// Execute stage: forwarding, B-source select, saturating ALU, sticky {Z,V,N} flags, EX/MEM register.
// Define EX_MUL_EN to build the iterative shift-add multiplier (op 0x4) and its IDLE/MUL/HOLD FSM.
module ex_stage_pipe #(
    parameter int DW  = 16,
    parameter int RW  = 4,
    parameter int SHW = $clog2(DW)
) (
    input  logic           clk,
    input  logic           rst,
    ex_stage_pipe_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_NAND = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_MUL  = 4'h4;
    localparam logic [3:0] OP_SRA  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_LHB  = 4'hA;
    localparam logic [3:0] OP_LLB  = 4'hB;

    logic           out_valid_q;
    logic [DW-1:0]  result_q;
    logic [DW-1:0]  store_q;
    logic [RW-1:0]  dst_q;
    logic           wb_q;
    logic [1:0]     mem_q;
    logic [2:0]     flags_q;

    logic           load_en;
    logic           accept;
    logic           fsm_idle;
    logic           start_mul;
    logic           hold_fire;
    logic [DW-1:0]  mul_res;
    logic [DW-1:0]  mul_store;
    logic [RW-1:0]  mul_dst;
    logic           mul_wb;
    logic [1:0]     mul_mem;

    logic [DW-1:0]  a_val;
    logic [DW-1:0]  rt_val;
    logic [DW-1:0]  b_val;
    logic [SHW-1:0] sh;
    logic [DW-1:0]  sum;
    logic [DW-1:0]  diff;
    logic [DW-1:0]  sat;
    logic [DW-1:0]  alu_res;
    logic           v_new;
    logic           upd_z;
    logic           upd_vn;

    assign load_en      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = fsm_idle && load_en;
    assign accept       = bus.in_valid && bus.in_ready;

    // Own output register beats the writeback stage; index 0 is hard zero and never forwarded.
    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] idx,      input logic [DW-1:0] rf,
        input logic          own_en,   input logic [RW-1:0] own_idx, input logic [DW-1:0] own_data,
        input logic          wbf_en,   input logic [RW-1:0] wbf_idx, input logic [DW-1:0] wbf_data
    );
        logic [DW-1:0] v;
        v = rf;
        if (idx != '0 && own_en && own_idx == idx)
            v = own_data;
        else if (idx != '0 && wbf_en && wbf_idx == idx)
            v = wbf_data;
        return v;
    endfunction

    assign a_val  = fwd_sel(bus.rs_idx, bus.rs_data, out_valid_q && wb_q, dst_q, result_q,
                            bus.wb_fwd_en, bus.wb_fwd_idx, bus.wb_fwd_data);
    assign rt_val = fwd_sel(bus.rt_idx, bus.rt_data, out_valid_q && wb_q, dst_q, result_q,
                            bus.wb_fwd_en, bus.wb_fwd_idx, bus.wb_fwd_data);

    always_comb begin
        b_val = rt_val;
        case (bus.alu_src)
            2'b00:   b_val = rt_val;
            2'b01:   b_val = bus.imm;
            2'b10:   b_val = bus.offset;
            default: b_val = {{(DW-1){1'b0}}, 1'b1};
        endcase
    end

    assign sh   = bus.shamt;
    assign sum  = a_val + b_val;
    assign diff = a_val - b_val;
    // Signed overflow always saturates toward the sign of a.
    assign sat  = a_val[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};

    always_comb begin
        alu_res = '0;
        v_new   = 1'b0;
        upd_z   = 1'b0;
        upd_vn  = 1'b0;
        case (bus.op)
            OP_ADD: begin
                v_new   = (a_val[DW-1] == b_val[DW-1]) && (sum[DW-1] != a_val[DW-1]);
                alu_res = v_new ? sat : sum;
                upd_vn  = 1'b1;
            end
            OP_SUB: begin
                v_new   = (a_val[DW-1] != b_val[DW-1]) && (diff[DW-1] != a_val[DW-1]);
                alu_res = v_new ? sat : diff;
                upd_vn  = 1'b1;
            end
            OP_NAND: begin alu_res = ~(a_val & b_val); upd_z = 1'b1; end
            OP_XOR:  begin alu_res = a_val ^ b_val;    upd_z = 1'b1; end
            OP_SRA:  begin alu_res = $signed(a_val) >>> sh; upd_z = 1'b1; end
            OP_SRL:  begin alu_res = a_val >> sh;      upd_z = 1'b1; end
            OP_SLL:  begin alu_res = a_val << sh;      upd_z = 1'b1; end
            OP_LHB:  alu_res = {b_val[7:0], a_val[DW-9:0]};
            OP_LLB:  alu_res = {a_val[DW-1:8], b_val[7:0]};
            default: alu_res = '0;
        endcase
    end

`ifdef EX_MUL_EN
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [DW-1:0]  m_cand;
    logic [DW-1:0]  m_plier;
    logic [DW-1:0]  acc;

    assign fsm_idle      = (state == S_IDLE);
    assign start_mul     = accept && (bus.op == OP_MUL);
    assign hold_fire     = (state == S_HOLD) && load_en;
    assign mul_res       = acc;
    assign bus.dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_mul) state_nxt = S_MUL;
            S_MUL:   if (cnt == '0) state_nxt = S_HOLD;
            S_HOLD:  if (load_en) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (bus.flush) state_nxt = S_IDLE;
    end

    // One shift-add step per MUL cycle; only the low DW product bits are kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            m_cand    <= '0;
            m_plier   <= '0;
            acc       <= '0;
            mul_store <= '0;
            mul_dst   <= '0;
            mul_wb    <= 1'b0;
            mul_mem   <= '0;
        end else if (state == S_IDLE && start_mul) begin
            cnt       <= CW'(DW - 1);
            m_cand    <= a_val;
            m_plier   <= b_val;
            acc       <= '0;
            mul_store <= rt_val;
            mul_dst   <= bus.dst_idx;
            mul_wb    <= bus.wb_in;
            mul_mem   <= bus.mem_in;
        end else if (state == S_MUL) begin
            if (m_plier[0]) acc <= acc + m_cand;
            m_cand  <= m_cand << 1;
            m_plier <= m_plier >> 1;
            if (cnt != '0) cnt <= cnt - 1'b1;
        end
    end
`else
    assign fsm_idle      = 1'b1;
    assign start_mul     = 1'b0;
    assign hold_fire     = 1'b0;
    assign mul_res       = '0;
    assign mul_store     = '0;
    assign mul_dst       = '0;
    assign mul_wb        = 1'b0;
    assign mul_mem       = '0;
    assign bus.dbg_state = 2'b00;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            store_q     <= '0;
            dst_q       <= '0;
            wb_q        <= 1'b0;
            mem_q       <= '0;
            flags_q     <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (load_en) begin
            if (hold_fire) begin
                out_valid_q <= 1'b1;
                result_q    <= mul_res;
                store_q     <= mul_store;
                dst_q       <= mul_dst;
                wb_q        <= mul_wb;
                mem_q       <= mul_mem;
            end else if (accept && !start_mul) begin
                out_valid_q <= 1'b1;
                result_q    <= alu_res;
                store_q     <= rt_val;
                dst_q       <= bus.dst_idx;
                wb_q        <= bus.wb_in;
                mem_q       <= bus.mem_in;
                if (upd_vn)
                    flags_q <= {(alu_res == '0), v_new, alu_res[DW-1]};
                else if (upd_z)
                    flags_q[2] <= (alu_res == '0);
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.store_data = store_q;
    assign bus.out_dst    = dst_q;
    assign bus.out_wb     = wb_q;
    assign bus.out_mem    = mem_q;
    assign bus.flags      = flags_q;
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: ALU ops, saturation, flags, forwarding, backpressure, flush, reset.
// The multiplier scenarios are compiled in when EX_MUL_EN is defined, otherwise op 0x4 is checked as unknown.
module tb_ex_stage_pipe;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ex_stage_pipe_if bus ();

    ex_stage_pipe dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.in_valid = 0; bus.op = 0; bus.alu_src = 0; bus.shamt = 0;
        bus.rs_data = 0; bus.rt_data = 0; bus.rs_idx = 0; bus.rt_idx = 0; bus.dst_idx = 0;
        bus.imm = 0; bus.offset = 0; bus.wb_in = 0; bus.mem_in = 0;
        bus.wb_fwd_en = 0; bus.wb_fwd_idx = 0; bus.wb_fwd_data = 0;
        bus.flush = 0; bus.out_ready = 1;
    endtask

    task automatic present(input logic [3:0] op, input logic [1:0] src,
                           input logic [3:0] rsi, input logic [15:0] rsd,
                           input logic [3:0] rti, input logic [15:0] rtd,
                           input logic [15:0] immv, input logic [3:0] shv,
                           input logic [3:0] dst, input logic wb);
        bus.op = op; bus.alu_src = src; bus.rs_idx = rsi; bus.rs_data = rsd;
        bus.rt_idx = rti; bus.rt_data = rtd; bus.imm = immv; bus.shamt = shv;
        bus.dst_idx = dst; bus.wb_in = wb; bus.in_valid = 1;
    endtask

    // Presents one instruction for one edge with the output side free; returns 1 time unit after the edge.
    task automatic issue(input logic [3:0] op, input logic [1:0] src,
                         input logic [3:0] rsi, input logic [15:0] rsd,
                         input logic [3:0] rti, input logic [15:0] rtd,
                         input logic [15:0] immv, input logic [3:0] shv,
                         input logic [3:0] dst, input logic wb);
        present(op, src, rsi, rsd, rti, rtd, immv, shv, dst, wb);
        @(posedge clk); #1;
        bus.in_valid = 0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bus.out_valid, bus.result, bus.store_data, bus.out_dst, bus.out_wb, bus.out_mem, bus.flags} !== 43'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b r=%h s=%h d=%h wb=%b mem=%b f=%b expected all 0",
                     bus.out_valid, bus.result, bus.store_data, bus.out_dst, bus.out_wb, bus.out_mem, bus.flags);
        end
        checks++;
        if ({bus.dbg_state, bus.in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_state got state=%0d in_ready=%b expected state=0 in_ready=1", bus.dbg_state, bus.in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_add_sub_sat();
        logic [15:0] rs_v [5]  = '{16'h7FFF, 16'h8000, 16'h0003, 16'h7FFF, 16'h8000};
        logic [15:0] imm_v[5]  = '{16'h0000, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'h0000};
        logic [1:0]  src_v[5]  = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b11};
        logic [3:0]  op_v [5]  = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1};
        logic [15:0] exp_r[5]  = '{16'h7FFF, 16'h8000, 16'h0001, 16'h7FFF, 16'h8000};
        logic [2:0]  exp_f[5]  = '{3'b010, 3'b011, 3'b000, 3'b010, 3'b011};
        for (int i = 0; i < 5; i++) begin
            bus.mem_in = 2'(i);
            issue(op_v[i], src_v[i], 4'd1, rs_v[i], 4'd0, 16'h0, imm_v[i], 4'd0, 4'd2, 1'b0);
            checks++;
            if ({bus.out_valid, bus.result, bus.flags, bus.out_dst, bus.out_mem} !== {1'b1, exp_r[i], exp_f[i], 4'd2, 2'(i)}) begin
                errors++;
                $display("FAIL add_sub_sat[%0d] got v=%b r=%h f=%b d=%0d mem=%0d expected v=1 r=%h f=%b d=2 mem=%0d",
                         i, bus.out_valid, bus.result, bus.flags, bus.out_dst, bus.out_mem, exp_r[i], exp_f[i], i);
            end
        end
        bus.mem_in = 0;
    endtask

    task automatic test_sub_zero_lhb();
        issue(4'h1, 2'b00, 4'd5, 16'h0005, 4'd6, 16'h0005, 16'h0, 4'd0, 4'd7, 1'b0);
        checks++;
        if ({bus.result, bus.flags, bus.store_data} !== {16'h0000, 3'b100, 16'h0005}) begin
            errors++;
            $display("FAIL sub_zero got r=%h f=%b s=%h expected r=0000 f=100 s=0005", bus.result, bus.flags, bus.store_data);
        end
        issue(4'hA, 2'b01, 4'd5, 16'h1234, 4'd0, 16'h0, 16'h00AB, 4'd0, 4'd7, 1'b0);
        checks++;
        if ({bus.result, bus.flags} !== {16'hAB34, 3'b100}) begin
            errors++;
            $display("FAIL lhb_flags got r=%h f=%b expected r=ab34 f=100", bus.result, bus.flags);
        end
    endtask

    task automatic test_logic_shift();
        logic [3:0]  op_v [8] = '{4'h0, 4'h3, 4'h2, 4'h5, 4'h6, 4'h7, 4'hB, 4'hF};
        logic [1:0]  src_v[8] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        logic [15:0] rs_v [8] = '{16'h8000, 16'h00FF, 16'hF0F0, 16'h8000, 16'h8000, 16'h0001, 16'h1234, 16'h1234};
        logic [15:0] rt_v [8] = '{16'h0000, 16'h0000, 16'h0FF0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h5678};
        logic [15:0] imm_v[8] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h00CD, 16'h0000};
        logic [3:0]  sh_v [8] = '{4'd0, 4'd0, 4'd0, 4'd3, 4'd3, 4'd15, 4'd0, 4'd0};
        logic [15:0] exp_r[8] = '{16'h8000, 16'h0000, 16'hFF0F, 16'hF000, 16'h1000, 16'h8000, 16'h12CD, 16'h0000};
        logic [2:0]  exp_f[8] = '{3'b011, 3'b111, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011};
        bus.offset = 16'h00FF;
        for (int i = 0; i < 8; i++) begin
            issue(op_v[i], src_v[i], 4'd1, rs_v[i], 4'd2, rt_v[i], imm_v[i], sh_v[i], 4'd9, 1'b0);
            checks++;
            if ({bus.out_valid, bus.result, bus.flags} !== {1'b1, exp_r[i], exp_f[i]}) begin
                errors++;
                $display("FAIL logic_shift[%0d] op=%h got v=%b r=%h f=%b expected v=1 r=%h f=%b",
                         i, op_v[i], bus.out_valid, bus.result, bus.flags, exp_r[i], exp_f[i]);
            end
        end
        bus.offset = 0;
    endtask

    task automatic test_forward_wb();
        bus.wb_fwd_en = 1; bus.wb_fwd_idx = 4'd9; bus.wb_fwd_data = 16'h0100;
        issue(4'h0, 2'b11, 4'd9, 16'h0000, 4'd0, 16'h0, 16'h0, 4'd0, 4'd10, 1'b0);
        checks++;
        if (bus.result !== 16'h0101) begin
            errors++;
            $display("FAIL fwd_wb_rs got %h expected 0101", bus.result);
        end
        bus.wb_fwd_idx = 4'd0; bus.wb_fwd_data = 16'h5555;
        issue(4'h0, 2'b11, 4'd0, 16'h0010, 4'd0, 16'h0, 16'h0, 4'd0, 4'd10, 1'b0);
        checks++;
        if (bus.result !== 16'h0011) begin
            errors++;
            $display("FAIL fwd_idx0 got %h expected 0011", bus.result);
        end
        bus.wb_fwd_idx = 4'd10; bus.wb_fwd_data = 16'h0AAA;
        issue(4'h3, 2'b00, 4'd1, 16'h0001, 4'd10, 16'h0000, 16'h0, 4'd0, 4'd11, 1'b0);
        checks++;
        if ({bus.result, bus.store_data} !== {16'h0AAB, 16'h0AAA}) begin
            errors++;
            $display("FAIL fwd_wb_rt got r=%h s=%h expected r=0aab s=0aaa", bus.result, bus.store_data);
        end
        bus.wb_fwd_en = 0;
    endtask

    task automatic test_back_to_back();
        issue(4'h0, 2'b00, 4'd1, 16'h0002, 4'd2, 16'h0003, 16'h0, 4'd0, 4'd3, 1'b1);
        checks++;
        if ({bus.result, bus.out_dst, bus.out_wb} !== {16'h0005, 4'd3, 1'b1}) begin
            errors++;
            $display("FAIL b2b_first got r=%h d=%0d wb=%b expected r=0005 d=3 wb=1", bus.result, bus.out_dst, bus.out_wb);
        end
        // Writeback also claims r3 with a different value; the younger own-register copy must win.
        bus.wb_fwd_en = 1; bus.wb_fwd_idx = 4'd3; bus.wb_fwd_data = 16'h7777;
        issue(4'h3, 2'b00, 4'd3, 16'h0000, 4'd6, 16'h00FF, 16'h0, 4'd0, 4'd4, 1'b1);
        checks++;
        if (bus.result !== 16'h00FA) begin
            errors++;
            $display("FAIL b2b_own_rs got %h expected 00fa", bus.result);
        end
        bus.wb_fwd_en = 0;
        issue(4'h0, 2'b00, 4'd0, 16'h0001, 4'd4, 16'h0000, 16'h0, 4'd0, 4'd15, 1'b0);
        checks++;
        if ({bus.result, bus.store_data} !== {16'h00FB, 16'h00FA}) begin
            errors++;
            $display("FAIL b2b_own_rt got r=%h s=%h expected r=00fb s=00fa", bus.result, bus.store_data);
        end
    endtask

    task automatic test_backpressure();
        bus.mem_in = 2'b01;
        issue(4'h0, 2'b11, 4'd1, 16'h0100, 4'd0, 16'h0, 16'h0, 4'd0, 4'd7, 1'b0);
        bus.out_ready = 0;
        present(4'h1, 2'b00, 4'd1, 16'h0200, 4'd2, 16'h0001, 16'h0, 4'd0, 4'd8, 1'b0);
        bus.mem_in = 2'b10;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.in_ready, bus.out_valid, bus.result, bus.out_dst, bus.out_mem, bus.flags} !==
                {1'b0, 1'b1, 16'h0101, 4'd7, 2'b01, 3'b000}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d] got rdy=%b v=%b r=%h d=%0d mem=%b f=%b expected rdy=0 v=1 r=0101 d=7 mem=01 f=000",
                         i, bus.in_ready, bus.out_valid, bus.result, bus.out_dst, bus.out_mem, bus.flags);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release got in_ready=%b expected 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 0;
        checks++;
        if ({bus.out_valid, bus.result, bus.out_dst, bus.out_mem} !== {1'b1, 16'h01FF, 4'd8, 2'b10}) begin
            errors++;
            $display("FAIL backpressure_next got v=%b r=%h d=%0d mem=%b expected v=1 r=01ff d=8 mem=10",
                     bus.out_valid, bus.result, bus.out_dst, bus.out_mem);
        end
        bus.mem_in = 0;
    endtask

    task automatic test_flush();
        issue(4'h0, 2'b01, 4'd1, 16'h8000, 4'd0, 16'h0, 16'hFFFF, 4'd0, 4'd2, 1'b0);
        present(4'h0, 2'b11, 4'd1, 16'h7FFF, 4'd0, 16'h0, 16'h0, 4'd0, 4'd2, 1'b0);
        bus.flush = 1;
        @(posedge clk); #1;
        bus.in_valid = 0; bus.flush = 0;
        checks++;
        if ({bus.out_valid, bus.flags, bus.dbg_state} !== {1'b0, 3'b011, 2'd0}) begin
            errors++;
            $display("FAIL flush_accept got v=%b f=%b state=%0d expected v=0 f=011 state=0", bus.out_valid, bus.flags, bus.dbg_state);
        end
        issue(4'h0, 2'b11, 4'd1, 16'h0001, 4'd0, 16'h0, 16'h0, 4'd0, 4'd2, 1'b0);
        checks++;
        if ({bus.out_valid, bus.result, bus.flags} !== {1'b1, 16'h0002, 3'b000}) begin
            errors++;
            $display("FAIL flush_recover got v=%b r=%h f=%b expected v=1 r=0002 f=000", bus.out_valid, bus.result, bus.flags);
        end
        bus.out_ready = 0; bus.flush = 1;
        @(posedge clk); #1;
        bus.flush = 0; bus.out_ready = 1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_stalled got v=%b expected 0", bus.out_valid);
        end
    endtask

`ifdef EX_MUL_EN
    task automatic test_op4();
        int n;
        int low;
        issue(4'h0, 2'b01, 4'd1, 16'h8000, 4'd0, 16'h0, 16'hFFFF, 4'd0, 4'd2, 1'b0);
        issue(4'h4, 2'b01, 4'd1, 16'h0012, 4'd0, 16'h0, 16'h0034, 4'd0, 4'd3, 1'b0);
        checks++;
        if ({bus.out_valid, bus.dbg_state} !== {1'b0, 2'd1}) begin
            errors++;
            $display("FAIL mul_start got v=%b state=%0d expected v=0 state=1", bus.out_valid, bus.dbg_state);
        end
        n = 0; low = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            if (bus.in_ready === 1'b0) low++;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if ({n, low} !== {32'd17, 32'd17}) begin
            errors++;
            $display("FAIL mul_timing got edges=%0d ready_low=%0d expected edges=17 ready_low=17", n, low);
        end
        checks++;
        if ({bus.out_valid, bus.result, bus.flags, bus.out_dst, bus.dbg_state} !== {1'b1, 16'h03A8, 3'b011, 4'd3, 2'd0}) begin
            errors++;
            $display("FAIL mul_result got v=%b r=%h f=%b d=%0d state=%0d expected v=1 r=03a8 f=011 d=3 state=0",
                     bus.out_valid, bus.result, bus.flags, bus.out_dst, bus.dbg_state);
        end
        issue(4'h4, 2'b01, 4'd1, 16'h0012, 4'd0, 16'h0, 16'h0034, 4'd0, 4'd3, 1'b0);
        repeat (5) @(posedge clk);
        #3 rst_n = 0;
        #1;
        checks++;
        if ({bus.out_valid, bus.result, bus.store_data, bus.out_dst, bus.flags, bus.dbg_state, bus.in_ready} !==
            {1'b0, 16'h0, 16'h0, 4'd0, 3'b000, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL mul_reset got v=%b r=%h s=%h d=%0d f=%b state=%0d rdy=%b expected all 0 with rdy=1",
                     bus.out_valid, bus.result, bus.store_data, bus.out_dst, bus.flags, bus.dbg_state, bus.in_ready);
        end
        #2 rst_n = 1;
        @(posedge clk); #1;
        issue(4'h0, 2'b11, 4'd1, 16'h0004, 4'd0, 16'h0, 16'h0, 4'd0, 4'd2, 1'b0);
        checks++;
        if ({bus.out_valid, bus.result} !== {1'b1, 16'h0005}) begin
            errors++;
            $display("FAIL mul_reset_recover got v=%b r=%h expected v=1 r=0005", bus.out_valid, bus.result);
        end
    endtask
`else
    task automatic test_op4();
        issue(4'h0, 2'b01, 4'd1, 16'h8000, 4'd0, 16'h0, 16'hFFFF, 4'd0, 4'd2, 1'b0);
        issue(4'h4, 2'b01, 4'd1, 16'h0012, 4'd0, 16'h0, 16'h0034, 4'd0, 4'd3, 1'b0);
        checks++;
        if ({bus.out_valid, bus.result, bus.flags, bus.in_ready, bus.dbg_state} !== {1'b1, 16'h0000, 3'b011, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL op4_unknown got v=%b r=%h f=%b rdy=%b state=%0d expected v=1 r=0000 f=011 rdy=1 state=0",
                     bus.out_valid, bus.result, bus.flags, bus.in_ready, bus.dbg_state);
        end
    endtask
`endif

    task automatic test_async_reset();
        issue(4'h0, 2'b01, 4'd1, 16'h7FFF, 4'd0, 16'h0, 16'h0001, 4'd0, 4'd6, 1'b1);
        #2 rst_n = 0;
        #1;
        checks++;
        if ({bus.out_valid, bus.result, bus.store_data, bus.out_dst, bus.out_wb, bus.out_mem, bus.flags} !== 43'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b r=%h s=%h d=%h wb=%b mem=%b f=%b expected all 0",
                     bus.out_valid, bus.result, bus.store_data, bus.out_dst, bus.out_wb, bus.out_mem, bus.flags);
        end
        #2 rst_n = 1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 0;
        idle_inputs();
        test_reset();
        test_add_sub_sat();
        test_sub_zero_lhb();
        test_logic_shift();
        test_forward_wb();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_op4();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
